hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Parametrised successor to the single-cycle load-use hazard detector in the 5-stage pipeline.
- Sits between the IF/ID and ID/EX registers. Detects load-use hazards against both the ID/EX and EX/MEM stages.
- Holds the PC and IF/ID for a configurable number of stall cycles, matched to memory load latency, with the ID/EX control bubbled.
- Arbitrates taken-branch flushes against stalls and keeps a saturating stall-cycle counter for performance analysis.

Parameters:
REG_W, 16, width of register-identifier buses
LOAD_LAT, 1, cycles a load result lags a dependent instruction in ID (legal 1..8); LOAD_LAT=1 equals the legacy one-bubble behaviour
ZERO_SAFE, 1, when 1 a destination of 0 never causes a hazard
CNT_W, 16, width of StallCount

Ports:
clk  input  1  pipeline clock, rising edge
rest  input  1  asynchronous active-low reset
MemRead_IDEX  input  1  instruction in ID/EX is a load
IDEX_Rd  input  REG_W  ID/EX destination register
MemRead_EXMEM  input  1  instruction in EX/MEM is a load
EXMEM_Rd  input  REG_W  EX/MEM destination register
IFID_Rs  input  REG_W  IF/ID source register 1
IFID_Rt  input  REG_W  IF/ID source register 2
IFID_UsesRt  input  1  IF/ID instruction actually reads Rt
BranchTaken  input  1  branch resolved taken this cycle
ControllSignal  output  1  1 = pass ID control to ID/EX, 0 = insert bubble
FrezeIFID  output  1  hold IF/ID register
FrezePC  output  1  hold PC
FlushIFID  output  1  clear IF/ID to NOP
StallCount  output  CNT_W  total stall cycles since reset, saturating

Behaviour:
- Match rule: matchX = (IFID_Rs==X) or (IFID_UsesRt and IFID_Rt==X). It is suppressed when ZERO_SAFE=1 and X==0.
- hazA = MemRead_IDEX and match(IDEX_Rd).
- hazB = (LOAD_LAT>=2) and MemRead_EXMEM and match(EXMEM_Rd).
- State: FSM {IDLE, STALL} plus a remaining-cycle counter rem (width enough for LOAD_LAT-1).
- Outputs are combinational from state and inputs. This gives the same-cycle response of the legacy block.
- Stall output set: ControllSignal=0, FrezeIFID=1, FrezePC=1, FlushIFID=0.
- Flush output set: ControllSignal=1, FrezeIFID=0, FrezePC=0, FlushIFID=1.
- Normal output set: ControllSignal=1, all others 0.
- IDLE:
  - BranchTaken: flush set for this cycle, stay IDLE. Branch has priority over any hazard.
  - Else hazA: stall set this cycle. If LOAD_LAT>=2, rem<=LOAD_LAT-1 and go to STALL.
  - Else hazB: stall set this cycle. If LOAD_LAT>=3, rem<=LOAD_LAT-2 and go to STALL.
  - Else normal set.
- STALL:
  - Stall set every cycle.
  - If rem==1, go to IDLE; otherwise rem<=rem-1.
  - BranchTaken in STALL: flush set this cycle, stall aborted, rem<=0, go to IDLE next cycle.
- Total stall length: LOAD_LAT cycles for hazA, LOAD_LAT-1 for hazB.
- In IDLE, hazards are re-evaluated each cycle. Back-to-back dependent loads produce back-to-back stall episodes with no gap cycle.
- Hazard inputs are ignored while in STALL.
- StallCount increments by 1 on each rising edge where the stall set was driven. It saturates at all-ones and is cleared only by reset.
- Reset (rest low, async):
  - state=IDLE, rem=0, StallCount=0.
  - Outputs are forced to the normal set while rest is low, regardless of inputs.
  - Reset asserted mid-stall drops the freeze immediately.
  - The first edge after rest rises evaluates from IDLE.

Test Plan:
- LOAD_LAT=1, MemRead_IDEX=1, IDEX_Rd=5, IFID_Rs=5 for 1 cycle -> 1 cycle ControllSignal=0, FrezePC=FrezeIFID=1; StallCount=1. Same with IFID_Rt=5 and IFID_UsesRt=0 -> no stall.
- LOAD_LAT=3, hazA on Rt=7 at cycle 0, then inputs cleared -> stall set in cycles 0,1,2, normal in cycle 3; StallCount=3. hazB only (EXMEM_Rd=7) -> stall for 2 cycles.
- ZERO_SAFE=1, IDEX_Rd=0, IFID_Rs=0, MemRead_IDEX=1 -> no stall. With ZERO_SAFE=0 -> 1 stall cycle.
- LOAD_LAT=4, hazA at cycle 0, BranchTaken=1 at cycle 2 -> stall in cycles 0-1; cycle 2 FlushIFID=1, ControllSignal=1, freezes 0; IDLE at cycle 3; StallCount=2. BranchTaken and hazA in the same IDLE cycle -> flush only.
- LOAD_LAT=3, hazA, rest driven low at cycle 1 -> outputs normal immediately and StallCount=0. After rest rises with no hazard -> normal outputs.
- CNT_W=4, continuous hazA with LOAD_LAT=1 for 20 cycles -> StallCount stops at 15 and stays there.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Load-use hazard detector and stall sequencer for the 5-stage pipeline.
//   Sits between IF/ID and ID/EX. Compares the IF/ID source registers against
//   loads sitting in ID/EX (hazA) and EX/MEM (hazB). It holds PC and IF/ID for
//   as many cycles as the load result lags, and bubbles the ID/EX control
//   meanwhile. A taken branch flushes IF/ID and wins over any stall. It also
//   keeps a saturating count of stall cycles.
//
// Parameters:
//   REG_W     width of register identifiers
//   LOAD_LAT  load-to-use latency in cycles (1..8); 1 = single bubble
//   ZERO_SAFE 1: destination register 0 never raises a hazard
//   CNT_W     width of StallCount
//
// Ports:
//   clk, rest             clock (rising edge), async active-low reset
//   MemRead_IDEX/IDEX_Rd  load flag / destination of the ID/EX instruction
//   MemRead_EXMEM/EXMEM_Rd load flag / destination of the EX/MEM instruction
//   IFID_Rs/IFID_Rt       source registers of the instruction in IF/ID
//   IFID_UsesRt           IF/ID instruction actually reads Rt
//   BranchTaken           branch resolved taken this cycle
//   ControllSignal        1 = pass ID control, 0 = insert bubble
//   FrezeIFID/FrezePC     hold IF/ID / hold PC
//   FlushIFID             clear IF/ID to NOP
//   StallCount            stall cycles since reset, saturating
module hazard_stall_controller #(
    parameter int REG_W     = 16,
    parameter int LOAD_LAT  = 1,
    parameter int ZERO_SAFE = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             MemRead_IDEX,
    input  logic [REG_W-1:0] IDEX_Rd,
    input  logic             MemRead_EXMEM,
    input  logic [REG_W-1:0] EXMEM_Rd,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             BranchTaken,
    output logic             ControllSignal,
    output logic             FrezeIFID,
    output logic             FrezePC,
    output logic             FlushIFID,
    output logic [CNT_W-1:0] StallCount
);

    // rem must hold LOAD_LAT-1 (at most 7)
    localparam int REM_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [REM_W-1:0]   rem_r, rem_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               haz_a_s, haz_b_s;
    logic               stall_s, flush_s;
    logic               stall_out_s, flush_out_s;

    // Source-operand match against a producer destination, with the
    // optional suppression of register 0 (hard-wired zero).
    function automatic logic match_f(
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        logic hit;
        hit = (rs == rd) || (uses_rt && (rt == rd));
        if ((ZERO_SAFE != 0) && (rd == {REG_W{1'b0}})) begin
            hit = 1'b0;
        end else begin
            hit = hit;
        end
        return hit;
    endfunction

    assign haz_a_s = MemRead_IDEX && match_f(IDEX_Rd, IFID_Rs, IFID_Rt, IFID_UsesRt);
    assign haz_b_s = (LOAD_LAT >= 2) && MemRead_EXMEM &&
                     match_f(EXMEM_Rd, IFID_Rs, IFID_Rt, IFID_UsesRt);

    // Next-state, remaining-cycle and stall/flush decision
    always_comb begin
        state_nxt_s = state_r;
        rem_nxt_s   = rem_r;
        stall_s     = 1'b0;
        flush_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (BranchTaken) begin
                    flush_s = 1'b1;
                end else if (haz_a_s) begin
                    stall_s = 1'b1;
                    if (LOAD_LAT >= 2) begin
                        rem_nxt_s   = REM_W'(LOAD_LAT - 1);
                        state_nxt_s = STALL;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (haz_b_s) begin
                    stall_s = 1'b1;
                    if (LOAD_LAT >= 3) begin
                        rem_nxt_s   = REM_W'(LOAD_LAT - 2);
                        state_nxt_s = STALL;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STALL: begin
                // Hazard inputs are deliberately ignored here; a taken
                // branch aborts the remaining stall.
                if (BranchTaken) begin
                    flush_s     = 1'b1;
                    rem_nxt_s   = {REM_W{1'b0}};
                    state_nxt_s = IDLE;
                end else begin
                    stall_s   = 1'b1;
                    rem_nxt_s = rem_r - REM_W'(1);
                    if (rem_r == REM_W'(1)) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = STALL;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
                rem_nxt_s   = {REM_W{1'b0}};
            end
        endcase
    end

    // Reset low forces the normal output set straight away, even mid-stall
    assign stall_out_s = stall_s && rest;
    assign flush_out_s = flush_s && rest;

    assign ControllSignal = ~stall_out_s;
    assign FrezeIFID      = stall_out_s;
    assign FrezePC        = stall_out_s;
    assign FlushIFID      = flush_out_s;
    assign StallCount     = cnt_r;

    // FSM state and remaining-cycle register
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_r <= IDLE;
            rem_r   <= {REM_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
        end
    end

    // Saturating stall-cycle counter, cleared only by reset
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (stall_out_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. Several parameterisations share
// one set of inputs; each test resets, drives a short sequence and checks the
// instance it targets. Inputs change 1 time unit after the rising edge and
// outputs are checked mid-cycle (at the falling edge).
module tb_hazard_stall_controller;

    logic        clk;
    logic        rest;
    logic        MemRead_IDEX, MemRead_EXMEM, IFID_UsesRt, BranchTaken;
    logic [15:0] IDEX_Rd, EXMEM_Rd, IFID_Rs, IFID_Rt;

    logic        ctl1, fif1, fpc1, fl1;   // LOAD_LAT=1, ZERO_SAFE=1
    logic [15:0] cnt1;
    logic        ctl3, fif3, fpc3, fl3;   // LOAD_LAT=3
    logic [15:0] cnt3;
    logic        ctl4, fif4, fpc4, fl4;   // LOAD_LAT=4
    logic [15:0] cnt4;
    logic        ctlz, fifz, fpcz, flz;   // LOAD_LAT=1, ZERO_SAFE=0
    logic [15:0] cntz;
    logic        ctlc, fifc, fpcc, flc;   // LOAD_LAT=1, CNT_W=4
    logic [3:0]  cntc;

    int checks = 0;
    int errors = 0;

    hazard_stall_controller #(.REG_W(16), .LOAD_LAT(1), .ZERO_SAFE(1), .CNT_W(16)) d1 (
        .clk(clk), .rest(rest), .MemRead_IDEX(MemRead_IDEX), .IDEX_Rd(IDEX_Rd),
        .MemRead_EXMEM(MemRead_EXMEM), .EXMEM_Rd(EXMEM_Rd), .IFID_Rs(IFID_Rs),
        .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt), .BranchTaken(BranchTaken),
        .ControllSignal(ctl1), .FrezeIFID(fif1), .FrezePC(fpc1), .FlushIFID(fl1),
        .StallCount(cnt1));

    hazard_stall_controller #(.REG_W(16), .LOAD_LAT(3), .ZERO_SAFE(1), .CNT_W(16)) d3 (
        .clk(clk), .rest(rest), .MemRead_IDEX(MemRead_IDEX), .IDEX_Rd(IDEX_Rd),
        .MemRead_EXMEM(MemRead_EXMEM), .EXMEM_Rd(EXMEM_Rd), .IFID_Rs(IFID_Rs),
        .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt), .BranchTaken(BranchTaken),
        .ControllSignal(ctl3), .FrezeIFID(fif3), .FrezePC(fpc3), .FlushIFID(fl3),
        .StallCount(cnt3));

    hazard_stall_controller #(.REG_W(16), .LOAD_LAT(4), .ZERO_SAFE(1), .CNT_W(16)) d4 (
        .clk(clk), .rest(rest), .MemRead_IDEX(MemRead_IDEX), .IDEX_Rd(IDEX_Rd),
        .MemRead_EXMEM(MemRead_EXMEM), .EXMEM_Rd(EXMEM_Rd), .IFID_Rs(IFID_Rs),
        .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt), .BranchTaken(BranchTaken),
        .ControllSignal(ctl4), .FrezeIFID(fif4), .FrezePC(fpc4), .FlushIFID(fl4),
        .StallCount(cnt4));

    hazard_stall_controller #(.REG_W(16), .LOAD_LAT(1), .ZERO_SAFE(0), .CNT_W(16)) dz (
        .clk(clk), .rest(rest), .MemRead_IDEX(MemRead_IDEX), .IDEX_Rd(IDEX_Rd),
        .MemRead_EXMEM(MemRead_EXMEM), .EXMEM_Rd(EXMEM_Rd), .IFID_Rs(IFID_Rs),
        .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt), .BranchTaken(BranchTaken),
        .ControllSignal(ctlz), .FrezeIFID(fifz), .FrezePC(fpcz), .FlushIFID(flz),
        .StallCount(cntz));

    hazard_stall_controller #(.REG_W(16), .LOAD_LAT(1), .ZERO_SAFE(1), .CNT_W(4)) dc (
        .clk(clk), .rest(rest), .MemRead_IDEX(MemRead_IDEX), .IDEX_Rd(IDEX_Rd),
        .MemRead_EXMEM(MemRead_EXMEM), .EXMEM_Rd(EXMEM_Rd), .IFID_Rs(IFID_Rs),
        .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt), .BranchTaken(BranchTaken),
        .ControllSignal(ctlc), .FrezeIFID(fifc), .FrezePC(fpcc), .FlushIFID(flc),
        .StallCount(cntc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        MemRead_IDEX  = 1'b0; IDEX_Rd  = 16'd0;
        MemRead_EXMEM = 1'b0; EXMEM_Rd = 16'd0;
        IFID_Rs = 16'd1; IFID_Rt = 16'd2; IFID_UsesRt = 1'b0;
        BranchTaken = 1'b0;
    endtask

    // Ends 1 unit after a rising edge with reset released: start of "cycle 0"
    task automatic do_reset();
        clear_inputs();
        rest = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rest = 1'b1;
    endtask

    // Advance to 1 unit after the next rising edge
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rest = 1'b0;
        MemRead_IDEX = 1'b1; IDEX_Rd = 16'd5; IFID_Rs = 16'd5;
        @(posedge clk); #4;
        checks++;
        if ({ctl1, fif1, fpc1, fl1} !== 4'b1000) begin
            errors++; $display("FAIL reset_outputs: got %b expected 1000", {ctl1, fif1, fpc1, fl1});
        end
        checks++;
        if (cnt1 !== 16'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", cnt1);
        end
    endtask

    task automatic test_lat1();
        do_reset();
        MemRead_IDEX = 1'b1; IDEX_Rd = 16'd5; IFID_Rs = 16'd5;
        #4;
        checks++;
        if ({ctl1, fif1, fpc1, fl1} !== 4'b0110) begin
            errors++; $display("FAIL lat1_stall: got %b expected 0110", {ctl1, fif1, fpc1, fl1});
        end
        next_cycle();
        IFID_Rs = 16'd3; IFID_Rt = 16'd5; IFID_UsesRt = 1'b0;
        #4;
        checks++;
        if (cnt1 !== 16'd1) begin
            errors++; $display("FAIL lat1_count: got %0d expected 1", cnt1);
        end
        checks++;
        if ({ctl1, fif1, fpc1, fl1} !== 4'b1000) begin
            errors++; $display("FAIL lat1_rt_unused: got %b expected 1000", {ctl1, fif1, fpc1, fl1});
        end
        IFID_UsesRt = 1'b1;
        #1;
        checks++;
        if (ctl1 !== 1'b0) begin
            errors++; $display("FAIL lat1_rt_used: got %b expected 0", ctl1);
        end
    endtask

    task automatic test_lat3();
        logic [3:0] exp_ctl;
        do_reset();
        MemRead_IDEX = 1'b1; IDEX_Rd = 16'd7; IFID_Rs = 16'd2; IFID_Rt = 16'd7; IFID_UsesRt = 1'b1;
        exp_ctl = 4'b1000;   // cycles 0..2 stalled, cycle 3 normal
        for (int c = 0; c < 4; c++) begin
            #4;
            checks++;
            if ({fpc3, ctl3} !== {~exp_ctl[c], exp_ctl[c]}) begin
                errors++; $display("FAIL lat3_hazA_cyc%0d: got ctl=%b frz=%b expected ctl=%b", c, ctl3, fpc3, exp_ctl[c]);
            end
            next_cycle();
            clear_inputs();
        end
        checks++;
        if (cnt3 !== 16'd3) begin
            errors++; $display("FAIL lat3_hazA_count: got %0d expected 3", cnt3);
        end
        do_reset();
        MemRead_EXMEM = 1'b1; EXMEM_Rd = 16'd7; IFID_Rs = 16'd7;
        exp_ctl = 4'b1100;   // cycles 0..1 stalled
        for (int c = 0; c < 3; c++) begin
            #4;
            checks++;
            if (ctl3 !== exp_ctl[c]) begin
                errors++; $display("FAIL lat3_hazB_cyc%0d: got %b expected %b", c, ctl3, exp_ctl[c]);
            end
            next_cycle();
            clear_inputs();
        end
        checks++;
        if (cnt3 !== 16'd2) begin
            errors++; $display("FAIL lat3_hazB_count: got %0d expected 2", cnt3);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        MemRead_IDEX = 1'b1; IDEX_Rd = 16'd0; IFID_Rs = 16'd0;
        #4;
        checks++;
        if (ctl1 !== 1'b1) begin
            errors++; $display("FAIL zero_safe1: got ctl=%b expected 1", ctl1);
        end
        checks++;
        if (ctlz !== 1'b0) begin
            errors++; $display("FAIL zero_safe0: got ctl=%b expected 0", ctlz);
        end
        next_cycle();
        clear_inputs();
        checks++;
        if ({cnt1, cntz} !== {16'd0, 16'd1}) begin
            errors++; $display("FAIL zero_counts: got %0d/%0d expected 0/1", cnt1, cntz);
        end
    endtask

    task automatic test_branch();
        do_reset();
        MemRead_IDEX = 1'b1; IDEX_Rd = 16'd9; IFID_Rs = 16'd9;
        #4;
        checks++;
        if ({ctl4, fif4, fpc4, fl4} !== 4'b0110) begin
            errors++; $display("FAIL br_cyc0: got %b expected 0110", {ctl4, fif4, fpc4, fl4});
        end
        next_cycle(); clear_inputs(); #4;
        checks++;
        if ({ctl4, fif4, fpc4, fl4} !== 4'b0110) begin
            errors++; $display("FAIL br_cyc1: got %b expected 0110", {ctl4, fif4, fpc4, fl4});
        end
        next_cycle(); BranchTaken = 1'b1; #4;
        checks++;
        if ({ctl4, fif4, fpc4, fl4} !== 4'b1001) begin
            errors++; $display("FAIL br_cyc2_flush: got %b expected 1001", {ctl4, fif4, fpc4, fl4});
        end
        next_cycle(); clear_inputs(); #4;
        checks++;
        if ({ctl4, fif4, fpc4, fl4} !== 4'b1000) begin
            errors++; $display("FAIL br_cyc3_idle: got %b expected 1000", {ctl4, fif4, fpc4, fl4});
        end
        checks++;
        if (cnt4 !== 16'd2) begin
            errors++; $display("FAIL br_count: got %0d expected 2", cnt4);
        end
        // Branch and hazard together in IDLE: flush wins
        next_cycle();
        BranchTaken = 1'b1; MemRead_IDEX = 1'b1; IDEX_Rd = 16'd9; IFID_Rs = 16'd9;
        #4;
        checks++;
        if ({ctl4, fif4, fpc4, fl4} !== 4'b1001) begin
            errors++; $display("FAIL br_vs_haz: got %b expected 1001", {ctl4, fif4, fpc4, fl4});
        end
        next_cycle(); clear_inputs(); #4;
        checks++;
        if ({ctl4, cnt4} !== {1'b1, 16'd2}) begin
            errors++; $display("FAIL br_vs_haz_after: got ctl=%b cnt=%0d expected ctl=1 cnt=2", ctl4, cnt4);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        MemRead_IDEX = 1'b1; IDEX_Rd = 16'd4; IFID_Rs = 16'd4;
        next_cycle();
        clear_inputs();
        rest = 1'b0;
        #1;
        checks++;
        if ({ctl3, fif3, fpc3, fl3, cnt3} !== {4'b1000, 16'd0}) begin
            errors++; $display("FAIL midrst: got %b cnt=%0d expected 1000 cnt=0", {ctl3, fif3, fpc3, fl3}, cnt3);
        end
        next_cycle();
        rest = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #4;
            checks++;
            if (ctl3 !== 1'b1) begin
                errors++; $display("FAIL midrst_after_cyc%0d: got ctl=%b expected 1", c, ctl3);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        MemRead_IDEX = 1'b1; IDEX_Rd = 16'd6; IFID_Rs = 16'd6;
        for (int c = 0; c < 6; c++) begin
            #4;
            checks++;
            if (ctl3 !== 1'b0) begin
                errors++; $display("FAIL b2b_cyc%0d: got ctl=%b expected 0", c, ctl3);
            end
            next_cycle();
        end
        clear_inputs();
        #4;
        checks++;
        if ({ctl3, cnt3} !== {1'b1, 16'd6}) begin
            errors++; $display("FAIL b2b_end: got ctl=%b cnt=%0d expected ctl=1 cnt=6", ctl3, cnt3);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        MemRead_IDEX = 1'b1; IDEX_Rd = 16'd8; IFID_Rs = 16'd8;
        for (int c = 0; c < 14; c++) next_cycle();
        checks++;
        if (cntc !== 4'd14) begin
            errors++; $display("FAIL sat_14: got %0d expected 14", cntc);
        end
        for (int c = 0; c < 6; c++) next_cycle();
        checks++;
        if (cntc !== 4'd15) begin
            errors++; $display("FAIL sat_20: got %0d expected 15", cntc);
        end
        clear_inputs();
        next_cycle();
        checks++;
        if (cntc !== 4'd15) begin
            errors++; $display("FAIL sat_hold: got %0d expected 15", cntc);
        end
    endtask

    initial begin
        test_reset();
        test_lat1();
        test_lat3();
        test_zero_reg();
        test_branch();
        test_reset_mid_stall();
        test_back_to_back();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
